// File: rtl/ram_programmer_if.sv
// Word-write bus from the UART loader to the RAM write-mux.
// The loader drives it as master; the RAM wrapper listens as slave.
interface ram_programmer_if;
  logic [31:0] prog_addr_o;
  logic [31:0] prog_data_o;
  logic        prog_valid_o;

  modport master (output prog_addr_o, output prog_data_o, output prog_valid_o);
  modport slave  (input  prog_addr_o, input  prog_data_o, input  prog_valid_o);
endinterface

// File: rtl/ram_programmer.sv
// UART-driven RAM loader: waits for a magic byte sequence, then receives a
// word count and little-endian words, emitting one write strobe per word.
module ram_programmer #(
  parameter int                      CLK_FREQ     = 50_000_000,
  parameter int                      BAUD_RATE    = 115_200,
  parameter int                      SEQ_LENGTH   = 8,
  parameter logic [8*SEQ_LENGTH-1:0] MAGIC_SEQ    = "CERESTST",
  parameter int                      BREAK_CYCLES = 1_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             uart_rx_i,
  ram_programmer_if.master prog,
  output logic             prog_mode_o,
  output logic             system_reset_o
);
  localparam int BIT_DIV  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BIT_DIV / 2;
  localparam int CNT_W    = $clog2(BIT_DIV + 1);
  localparam int IDX_W    = $clog2(SEQ_LENGTH + 1);
  localparam int TMR_W    = $clog2(BREAK_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, MATCH, COUNT, DATA, DONE} state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic             rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic             byte_valid_q, byte_valid_d;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_next;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      asm_q, asm_d, word_count_q, word_count_d, words_done_q, words_done_d;
  logic [31:0]      assembled;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [31:0]      addr_q, addr_d, data_q, data_d;
  logic             valid_q, valid_d, mode_q, mode_d;

  // Magic bytes are indexed from the most-significant (first received) byte.
  function automatic logic [7:0] magic_byte(input logic [IDX_W-1:0] i);
    magic_byte = 8'h00;
    for (int k = 0; k < SEQ_LENGTH; k++)
      if (i == IDX_W'(k)) magic_byte = MAGIC_SEQ[8*(SEQ_LENGTH-1-k) +: 8];
  endfunction

  always_comb begin
    rx_meta_d    = uart_rx_i;
    rx_sync_d    = rx_meta_q;
    rx_prev_d    = rx_sync_q;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
      end
      RX_START: begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (rx_cnt_q == CNT_W'(HALF_DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (rx_cnt_q == CNT_W'(BIT_DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      default: begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (rx_cnt_q == CNT_W'(BIT_DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          // A low stop bit is a framing error; the byte is silently dropped.
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = rx_shift_q;
          end
        end
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    idx_next     = '0;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    assembled    = {rx_byte_q, asm_q[31:8]};
    word_count_d = word_count_q;
    words_done_d = words_done_q;
    timer_d      = '0;
    addr_d       = addr_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    case (state_q)
      IDLE, MATCH: if (byte_valid_q) begin
        if (rx_byte_q == magic_byte(idx_q)) idx_next = idx_q + IDX_W'(1);
        else if (rx_byte_q == magic_byte(IDX_W'(0))) idx_next = IDX_W'(1);
        if (idx_next == IDX_W'(SEQ_LENGTH)) begin
          state_d    = COUNT;
          idx_d      = '0;
          byte_cnt_d = '0;
        end else begin
          idx_d   = idx_next;
          state_d = (idx_next == '0) ? IDLE : MATCH;
        end
      end
      COUNT, DATA: begin
        timer_d = timer_q + TMR_W'(1);
        if (state_q == DATA && valid_q) begin
          addr_d = addr_q + 32'd1;
          if (words_done_q == word_count_q) state_d = DONE;
        end
        if (byte_valid_q) begin
          timer_d    = '0;
          asm_d      = assembled;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (state_q == COUNT) begin
              word_count_d = assembled;
              words_done_d = '0;
              addr_d       = '0;
              state_d      = (assembled == 32'd0) ? DONE : DATA;
            end else begin
              data_d       = assembled;
              valid_d      = 1'b1;
              words_done_d = words_done_q + 32'd1;
            end
          end
        end else if (timer_q == TMR_W'(BREAK_CYCLES - 1)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d    = IDLE;
        idx_d      = '0;
        byte_cnt_d = '0;
      end
    endcase
  end

  assign mode_d = (state_d == COUNT) || (state_d == DATA);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      state_q      <= IDLE;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      word_count_q <= '0;
      words_done_q <= '0;
      timer_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      mode_q       <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      word_count_q <= word_count_d;
      words_done_q <= words_done_d;
      timer_q      <= timer_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      mode_q       <= mode_d;
    end
  end

  assign prog.prog_addr_o  = addr_q;
  assign prog.prog_data_o  = data_q;
  assign prog.prog_valid_o = valid_q;
  assign prog_mode_o       = mode_q;
  assign system_reset_o    = mode_q;
endmodule

// File: tb/tb_ram_programmer.sv
// Bench for ram_programmer: serial byte streams are driven on the RX pin and the
// captured writes and mode behaviour are compared against a byte-level model.
module tb_ram_programmer;
  localparam int BIT_DIV      = 10;
  localparam int SEQ_LENGTH   = 4;
  localparam int BREAK_CYCLES = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic mode, sysrst;
  logic [31:0] magic_v = "PROG";

  ram_programmer_if prog_bus ();

  ram_programmer #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .SEQ_LENGTH(SEQ_LENGTH),
    .MAGIC_SEQ(32'h50524F47), .BREAK_CYCLES(BREAK_CYCLES)
  ) dut (
    .clk_i(clk), .rst_i(rst), .uart_rx_i(rx), .prog(prog_bus),
    .prog_mode_o(mode), .system_reset_o(sysrst)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  stim_q[$];
  int          bad_idx = -1;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  int          mode_rises = 0;
  int          violations = 0;
  int          exp_entries;
  logic        exp_final_mode;
  logic        mode_prev = 1'b0;
  logic        valid_prev = 1'b0;

  // Records every write strobe and flags strobes outside programming mode,
  // strobes longer than one cycle, and disagreement between the two mode outputs.
  always @(negedge clk) begin
    if (!rst) begin
      if (prog_bus.prog_valid_o) got_q.push_back({prog_bus.prog_addr_o, prog_bus.prog_data_o});
      if (prog_bus.prog_valid_o && !mode) violations++;
      if (prog_bus.prog_valid_o && valid_prev) violations++;
      if (mode && !mode_prev) mode_rises++;
      if (sysrst !== mode) violations++;
    end
    valid_prev = prog_bus.prog_valid_o;
    mode_prev  = mode;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] magicByte(input int i);
    return magic_v[8*(SEQ_LENGTH-1-i) +: 8];
  endfunction

  task automatic sendByte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (BIT_DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_DIV) @(posedge clk);
    end
    rx = !bad_stop;
    repeat (BIT_DIV) @(posedge clk);
    rx = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic applyStimulus(input int from, input int upto);
    for (int i = from; i < upto; i++) sendByte(stim_q[i], i == bad_idx);
  endtask

  task automatic pushMagic();
    for (int i = 0; i < SEQ_LENGTH; i++) stim_q.push_back(magicByte(i));
  endtask

  task automatic pushWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stim_q.push_back(w[8*i +: 8]);
  endtask

  // Byte-level reference: magic search with the first-byte restart rule, then
  // a little-endian count and that many little-endian words at addresses 0,1,...
  task automatic modelStream(input int upto, input bit timeout);
    int phase, idx, k, nwords;
    logic [31:0] cnt, word;
    exp_q.delete();
    exp_entries = 0;
    phase = 0; idx = 0; k = 0; nwords = 0; cnt = '0; word = '0;
    for (int i = 0; i < upto; i++) begin
      logic [7:0] b;
      b = stim_q[i];
      if (i == bad_idx) continue;
      if (phase == 0) begin
        if (b == magicByte(idx)) idx++;
        else idx = (b == magicByte(0)) ? 1 : 0;
        if (idx == SEQ_LENGTH) begin
          phase = 1; k = 0; cnt = '0; exp_entries++;
        end
      end else if (phase == 1) begin
        cnt[8*k +: 8] = b;
        k++;
        if (k == 4) begin
          k = 0; idx = 0; nwords = 0;
          phase = (cnt == 0) ? 0 : 2;
        end
      end else begin
        word[8*k +: 8] = b;
        k++;
        if (k == 4) begin
          exp_q.push_back({32'(nwords), word});
          nwords++;
          k = 0;
          if (nwords == int'(cnt)) phase = 0;
        end
      end
    end
    if (timeout) phase = 0;
    exp_final_mode = (phase != 0);
  endtask

  task automatic startScenario();
    @(posedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    got_q.delete();
    stim_q.delete();
    bad_idx = -1;
    mode_rises = 0;
    violations = 0;
  endtask

  task automatic finishScenario(input string name, input bit timeout);
    repeat (timeout ? BREAK_CYCLES + 100 : 100) @(posedge clk);
    @(negedge clk);
    modelStream(stim_q.size(), timeout);
    checkOutput({name, " write count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      checkOutput($sformatf("%s write %0d addr/data", name, i), got_q[i], exp_q[i]);
    checkOutput({name, " mode entries"}, 64'(mode_rises), 64'(exp_entries));
    checkOutput({name, " final mode"}, 64'(mode), 64'(exp_final_mode));
    checkOutput({name, " protocol violations"}, 64'(violations), 64'd0);
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, " addr"}, 64'(prog_bus.prog_addr_o), 64'd0);
    checkOutput({name, " data"}, 64'(prog_bus.prog_data_o), 64'd0);
    checkOutput({name, " valid"}, 64'(prog_bus.prog_valid_o), 64'd0);
    checkOutput({name, " mode"}, 64'(mode), 64'd0);
    checkOutput({name, " sysreset"}, 64'(sysrst), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");

    startScenario();
    pushMagic();
    stim_q.push_back(8'h02); stim_q.push_back(8'h00); stim_q.push_back(8'h00); stim_q.push_back(8'h00);
    pushWord(32'h12345678);
    pushWord(32'hDEADBEEF);
    applyStimulus(0, SEQ_LENGTH);
    @(negedge clk);
    checkOutput("basic mode after magic", 64'(mode), 64'd1);
    checkOutput("basic sysreset after magic", 64'(sysrst), 64'd1);
    applyStimulus(SEQ_LENGTH, stim_q.size());
    finishScenario("basic", 1'b0);

    startScenario();
    stim_q.push_back("P");
    pushMagic();
    stim_q.push_back(8'h01); stim_q.push_back(8'h00); stim_q.push_back(8'h00); stim_q.push_back(8'h00);
    pushWord($urandom);
    applyStimulus(0, stim_q.size());
    finishScenario("pprog", 1'b0);

    startScenario();
    stim_q.push_back("P"); stim_q.push_back("R"); stim_q.push_back("X"); stim_q.push_back("G");
    pushMagic();
    stim_q.push_back(8'h01); stim_q.push_back(8'h00); stim_q.push_back(8'h00); stim_q.push_back(8'h00);
    pushWord($urandom);
    applyStimulus(0, 4);
    @(negedge clk);
    checkOutput("prxg no early entry", 64'(mode), 64'd0);
    applyStimulus(4, stim_q.size());
    finishScenario("prxg", 1'b0);

    startScenario();
    pushMagic();
    stim_q.push_back(8'h03); stim_q.push_back(8'h00); stim_q.push_back(8'h00); stim_q.push_back(8'h00);
    pushWord($urandom);
    applyStimulus(0, stim_q.size());
    finishScenario("timeout", 1'b1);

    startScenario();
    pushMagic();
    bad_idx = 2;
    applyStimulus(0, stim_q.size());
    finishScenario("badstop", 1'b0);

    startScenario();
    pushMagic();
    for (int i = 0; i < 4; i++) stim_q.push_back(8'h00);
    applyStimulus(0, stim_q.size());
    finishScenario("count0", 1'b0);

    for (int r = 0; r < 4; r++) begin
      int n, cnt;
      startScenario();
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        int pick;
        pick = $urandom_range(0, 4);
        stim_q.push_back(pick < 4 ? magicByte(pick) : 8'($urandom));
      end
      pushMagic();
      cnt = $urandom_range(1, 3);
      pushWord(32'(cnt));
      for (int i = 0; i < cnt; i++) pushWord($urandom);
      applyStimulus(0, stim_q.size());
      finishScenario($sformatf("random%0d", r), 1'b0);
    end

    startScenario();
    pushMagic();
    pushWord(32'd2);
    pushWord($urandom);
    stim_q.push_back(8'($urandom)); stim_q.push_back(8'($urandom));
    applyStimulus(0, stim_q.size());
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("midreset");
    rst = 1'b0;
    modelStream(stim_q.size(), 1'b0);
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checkOutput("midreset write count", 64'(got_q.size()), 64'(exp_q.size()));
    checkOutput("midreset mode", 64'(mode), 64'd0);
    checkOutput("midreset violations", 64'(violations), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_programmer.md
Name: ram_programmer

Overview:
- UART-driven loader that writes a program image into the system RAM one 32-bit word at a time.
- Idles and monitors a serial RX line for a magic byte sequence. On a match it enters programming mode and holds the system in reset.
- In programming mode it receives a word count followed by data words, and emits word-addressed write strobes to the RAM wrapper.
- Sits between the board programming UART pin and the RAM write-mux.

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- BAUD_RATE, 115_200, UART baud rate. Bit period BIT_DIV = CLK_FREQ/BAUD_RATE, integer floor.
- SEQ_LENGTH, 8, number of bytes in the magic sequence (>=1).
- MAGIC_SEQ, "CERESTST" (8*SEQ_LENGTH bits), magic bytes. The most-significant byte is received first.
- BREAK_CYCLES, 1_000_000, inactivity timeout in clocks while in programming mode.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- uart_rx_i  in  1  asynchronous serial input, 8N1, idle high.
- prog_addr_o  out  32  word index of the current write (byte address / 4), starting at 0.
- prog_data_o  out  32  word to write.
- prog_valid_o  out  1  one-cycle write strobe; addr/data valid in the same cycle.
- prog_mode_o  out  1  high while in programming mode.
- system_reset_o  out  1  high while in programming mode; holds the CPU in reset.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, match index 0, counters 0. A reset mid-programming aborts immediately, with no further prog_valid_o.
- UART receiver:
  - uart_rx_i passes through a 2-FF synchronizer.
  - A falling edge while idle starts a frame. The start bit is re-checked at BIT_DIV/2; if the line is high, the frame is discarded.
  - 8 data bits are sampled at bit centres, LSB first.
  - The stop bit must be 1. A 0 is a framing error and the byte is dropped.
  - A good byte raises an internal byte_valid for 1 cycle, at the stop-bit sample.
- FSM states: IDLE, MATCH, COUNT, DATA, DONE.
- IDLE/MATCH:
  - Each good byte is compared with MAGIC_SEQ byte[idx].
  - Equal: idx++.
  - Unequal: idx = (byte == first magic byte) ? 1 : 0.
  - When idx reaches SEQ_LENGTH, go to COUNT. prog_mode_o and system_reset_o go high on the following clock.
- COUNT: receive 4 bytes, little-endian, forming word_count.
  - If word_count == 0, go to DONE.
  - Otherwise clear prog_addr_o to 0 and go to DATA.
- DATA: assemble each group of 4 bytes little-endian (first byte is bits [7:0]) into prog_data_o.
  - On the 4th byte, prog_valid_o pulses for exactly 1 cycle. Latency is 1 clock after that byte's byte_valid.
  - prog_addr_o increments in the cycle after the pulse.
  - After word_count words, go to DONE.
- DONE: for one cycle, prog_mode_o and system_reset_o drop to 0. Then return to IDLE with idx 0.
- Timeout:
  - In COUNT or DATA, a free-running counter is cleared on every good byte.
  - When it reaches BREAK_CYCLES, go to DONE (abort). Words already written remain written.
- Magic bytes received while in COUNT or DATA are treated as data, not as a restart.
- prog_data_o and prog_addr_o hold their last values outside pulses. prog_valid_o is never high outside DATA.
- prog_addr_o wraps modulo 2^32; no range check is done. The wrapper truncates it.

Test Plan:
- Bench setup: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BIT_DIV=10), SEQ_LENGTH=4, MAGIC_SEQ="PROG".
- Send "PROG", count 2 (02 00 00 00), words 78 56 34 12 and EF BE AD DE -> prog_mode_o and system_reset_o rise after the 'G' byte. Two prog_valid_o pulses: (addr 0, data 0x12345678) then (addr 1, data 0xDEADBEEF). Then prog_mode_o returns to 0.
- Send "PPROG" -> match still succeeds via the first-byte restart rule; prog_mode_o becomes 1.
- Send "PRXG" then "PROG" -> no mode entry after the first four bytes; entry occurs after the second "PROG".
- Send "PROG", count 3, only one full word, then idle for BREAK_CYCLES -> one prog_valid_o pulse (addr 0), then timeout abort: prog_mode_o=0 and FSM back in IDLE.
- Byte with its stop bit forced to 0 inside the magic sequence -> byte dropped, no mode entry. Count 0 after a valid magic -> mode pulses high, then returns low with no prog_valid_o.
- Assert rst_i mid-DATA -> all outputs 0 on the next clock and no further prog_valid_o.
